// File: rtl/aes_tlu_pipe_if.sv
// Handshake bundle for aes_tlu_pipe: request channel (in_*) and result channel (out_*).
// With AES_TLU_PARITY_EN defined, the bundle also carries the out_par byte-parity vector.
interface aes_tlu_pipe_if #(
    parameter int LANES = 4,
    parameter int TAG_W = 4
);
    // valid/ready: a transfer happens on a rising clk edge where valid && ready are both high;
    // a producer holding valid keeps its payload unchanged until that transfer happens.
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_mode;
    logic [TAG_W-1:0]       in_tag;
    logic [LANES*32-1:0]    in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [TAG_W-1:0]       out_tag;
    logic [LANES*128-1:0]   out_data;
`ifdef AES_TLU_PARITY_EN
    logic [LANES*16-1:0]    out_par;

    modport master (
        output in_valid, in_mode, in_tag, in_state, out_ready,
        input  in_ready, out_valid, out_tag, out_data, out_par
    );
    modport slave (
        input  in_valid, in_mode, in_tag, in_state, out_ready,
        output in_ready, out_valid, out_tag, out_data, out_par
    );
`else
    modport master (
        output in_valid, in_mode, in_tag, in_state, out_ready,
        input  in_ready, out_valid, out_tag, out_data
    );
    modport slave (
        input  in_valid, in_mode, in_tag, in_state, out_ready,
        output in_ready, out_valid, out_tag, out_data
    );
`endif
endinterface

// File: rtl/aes_tlu_pipe.sv
// Two-stage, flow-controlled AES T-table / SubWord lookup for LANES 32-bit words per transaction.
// Optional macro AES_TLU_PARITY_EN adds a registered even-parity bit per output byte (out_par).
module aes_tlu_pipe #(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    aes_tlu_pipe_if.slave tlu
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] t_word(input logic [7:0] s, input logic [7:0] xs);
        return {s, s, s ^ xs, xs};
    endfunction

    // s_bytes/xs_bytes hold S and xS of b0..b3, b0 in the top byte.
    function automatic logic [127:0] lane_result(input logic mode, input logic [31:0] s_bytes,
                                                 input logic [31:0] xs_bytes);
        logic [31:0] x0, x1, x2, x3;
        x0 = t_word(s_bytes[31:24], xs_bytes[31:24]);
        x1 = t_word(s_bytes[23:16], xs_bytes[23:16]);
        x2 = t_word(s_bytes[15:8],  xs_bytes[15:8]);
        x3 = t_word(s_bytes[7:0],   xs_bytes[7:0]);
        if (mode) begin
            return {s_bytes, 96'd0};
        end
        return {x0[7:0], x0[31:8], x1[15:0], x1[31:16], x2[23:0], x2[31:24], x3};
    endfunction

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_s2_load;
    logic [LANES*32-1:0]  w_rom_addr;
    logic [LANES*128-1:0] w_s1_data;

    logic [LANES*32-1:0]  r_held_state;
    logic [LANES*32-1:0]  r_rom_s;
    logic [LANES*32-1:0]  r_rom_xs;
    logic                 r_s1_valid;
    logic                 r_s1_mode;
    logic [TAG_W-1:0]     r_s1_tag;
    logic                 r_out_valid;
    logic [TAG_W-1:0]     r_out_tag;
    logic [LANES*128-1:0] r_out_data;

    assign w_in_ready = !r_s1_valid || !r_out_valid || tlu.out_ready;
    assign w_accept   = tlu.in_valid && w_in_ready;
    assign w_s2_load  = r_s1_valid && (!r_out_valid || tlu.out_ready);

    // The ROM cells have no enable: while stalled, re-address them with the held word so
    // their registered outputs keep describing the entry parked in stage 1.
    assign w_rom_addr = w_in_ready ? tlu.in_state : r_held_state;

    always_ff @(posedge clk) begin : rom_cells
        for (int k = 0; k < LANES * 4; k++) begin
            r_rom_s[k*8 +: 8]  <= SBOX[w_rom_addr[k*8 +: 8]];
            r_rom_xs[k*8 +: 8] <= xtime(SBOX[w_rom_addr[k*8 +: 8]]);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_s1_data[l*128 +: 128] = lane_result(r_s1_mode, r_rom_s[l*32 +: 32], r_rom_xs[l*32 +: 32]);
    end

    always_ff @(posedge clk) begin : stage1
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_mode    <= 1'b0;
            r_s1_tag     <= '0;
            r_held_state <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= tlu.in_valid;
            if (w_accept) begin
                r_s1_mode    <= tlu.in_mode;
                r_s1_tag     <= tlu.in_tag;
                r_held_state <= tlu.in_state;
            end
        end
    end

`ifdef AES_TLU_PARITY_EN
    logic [LANES*16-1:0] w_s1_par;
    logic [LANES*16-1:0] r_out_par;

    for (genvar j = 0; j < LANES * 16; j++) begin : g_par
        assign w_s1_par[j] = ^w_s1_data[j*8 +: 8];
    end

    always_ff @(posedge clk) begin : stage2_par
        if (rst) begin
            r_out_par <= '0;
        end else if (w_s2_load) begin
            r_out_par <= w_s1_par;
        end
    end

    assign tlu.out_par = r_out_par;
`endif

    always_ff @(posedge clk) begin : stage2
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_tag   <= r_s1_tag;
            r_out_data  <= w_s1_data;
        end else if (tlu.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign tlu.in_ready  = w_in_ready;
    assign tlu.out_valid = r_out_valid;
    assign tlu.out_tag   = r_out_tag;
    assign tlu.out_data  = r_out_data;

endmodule

// File: tb/tb_aes_tlu_pipe.sv
// Self-checking bench for aes_tlu_pipe: directed hand vectors plus a scoreboarded stream monitor.
module tb_aes_tlu_pipe;
    localparam int LANES = 4;
    localparam int TAG_W = 4;
    localparam int DW    = LANES * 128;
    localparam int SW    = LANES * 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_tlu_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    aes_tlu_pipe #(.LANES(LANES), .TAG_W(TAG_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .tlu (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, then the AES affine map.
    function automatic logic [7:0] sbox_m(input logic [7:0] a);
        logic [7:0] r, t, s;
        r = 8'h01; t = a;
        for (int i = 0; i < 7; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        for (int i = 0; i < 8; i++)
            s[i] = r[i] ^ r[(i+4)%8] ^ r[(i+5)%8] ^ r[(i+6)%8] ^ r[(i+7)%8];
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] lane_ref(input logic [31:0] w, input logic md);
        logic [7:0]  s [4];
        logic [31:0] t [4];
        for (int b = 0; b < 4; b++) begin
            s[b] = sbox_m(w[31-8*b -: 8]);
            t[b] = {s[b], s[b], s[b] ^ xt(s[b]), xt(s[b])};
        end
        if (md) return {s[0], s[1], s[2], s[3], 96'd0};
        return {t[0][7:0], t[0][31:8], t[1][15:0], t[1][31:16], t[2][23:0], t[2][31:24], t[3]};
    endfunction

    function automatic logic [DW-1:0] txn_ref(input logic [SW-1:0] st, input logic md);
        logic [DW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*128 +: 128] = lane_ref(st[l*32 +: 32], md);
        return r;
    endfunction

    function automatic logic [SW-1:0] rep(input logic [31:0] w);
        return {LANES{w}};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [DW-1:0]    exp_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    bit               mon_en = 1'b0;
    int               n_out = 0;
    logic             prev_stall = 1'b0;
    logic [DW-1:0]    prev_data;
    logic [TAG_W-1:0] prev_tag;

    always @(negedge clk) begin
        logic [DW-1:0]    e_data;
        logic [TAG_W-1:0] e_tag;
        if (mon_en && !rst) begin
            if (prev_stall) begin
                check("hold_valid", DW'(bus.out_valid), DW'(1'b1));
                check("hold_data", bus.out_data, prev_data);
                check("hold_tag", DW'(bus.out_tag), DW'(prev_tag));
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(txn_ref(bus.in_state, bus.in_mode));
                exp_tag_q.push_back(bus.in_tag);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_out", DW'(bus.out_valid), DW'(1'b0));
                end else begin
                    e_data = exp_q.pop_front();
                    e_tag  = exp_tag_q.pop_front();
                    check("sb_data", bus.out_data, e_data);
                    check("sb_tag", DW'(bus.out_tag), DW'(e_tag));
`ifdef AES_TLU_PARITY_EN
                    begin
                        logic [LANES*16-1:0] e_par;
                        for (int j = 0; j < LANES * 16; j++) e_par[j] = ^e_data[j*8 +: 8];
                        check("sb_par", DW'(bus.out_par), DW'(e_par));
                    end
`endif
                end
                n_out++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_tag   = bus.out_tag;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SW-1:0] st, input logic md, input logic [TAG_W-1:0] tg);
        int budget;
        bus.in_valid = 1'b1;
        bus.in_state = st;
        bus.in_mode  = md;
        bus.in_tag   = tg;
        budget = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            budget++;
            if (budget > 200) begin
                check("send_timeout", DW'(bus.in_ready), DW'(1'b1));
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int budget;
        budget = 0;
        while (n_out < n && budget < 500) begin
            cycle();
            budget++;
        end
        check("drain_count", DW'(n_out), DW'(n));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [SW-1:0] st;
        int            guard;

        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_tag    = '0;
        bus.in_state  = '0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", DW'(bus.in_ready), DW'(1'b1));
        check("rst_out_valid", DW'(bus.out_valid), DW'(1'b0));
        check("rst_out_data", bus.out_data, '0);
        check("rst_out_tag", DW'(bus.out_tag), '0);

        // mode 0 hand vectors, latency of exactly two cycles
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b0;
        bus.in_tag   = 4'h3;
        bus.in_state = {32'h0, 32'h00010203, 32'h01010101, 32'h00000000};
        cycle();
        bus.in_valid = 1'b0;
        check("t0_lat_n1", DW'(bus.out_valid), DW'(1'b0));
        cycle();
        check("t0_lat_n2", DW'(bus.out_valid), DW'(1'b1));
        check("t0_lane0", DW'(bus.out_data[0 +: 128]), DW'(128'hc66363a5_a5c66363_63a5c663_6363a5c6));
        check("t0_lane1", DW'(bus.out_data[128 +: 128]), DW'(128'hf87c7c84_84f87c7c_7c84f87c_7c7c84f8));
        check("t0_lane2", DW'(bus.out_data[256 +: 128]), DW'(128'hc66363a5_84f87c7c_7799ee77_7b7b8df6));
        check("t0_tag", DW'(bus.out_tag), DW'(4'h3));
        cycle();
        check("t0_drained", DW'(bus.out_valid), DW'(1'b0));

        // mode 1 (SubWord)
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        bus.in_tag   = 4'h5;
        bus.in_state = {32'h0, 32'h0, 32'h53535353, 32'h00010203};
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        check("sw_valid", DW'(bus.out_valid), DW'(1'b1));
        check("sw_lane0", DW'(bus.out_data[0 +: 128]), DW'(128'h637c777b_00000000_00000000_00000000));
        check("sw_lane1", DW'(bus.out_data[128 +: 128]), DW'(128'hedededed_00000000_00000000_00000000));
        check("sw_tag", DW'(bus.out_tag), DW'(4'h5));
        cycle();

        // 16 back-to-back transactions, one result per cycle
        n_out  = 0;
        mon_en = 1'b1;
        bus.in_mode = 1'b0;
        for (int k = 0; k < 19; k++) begin
            if (k < 16) begin
                bus.in_valid = 1'b1;
                bus.in_state = rep(32'(k) * 32'h01010101);
                bus.in_tag   = TAG_W'(k);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (k < 16) check($sformatf("b2b_in_ready_%0d", k), DW'(bus.in_ready), DW'(1'b1));
            check($sformatf("b2b_out_valid_%0d", k), DW'(bus.out_valid), DW'(k >= 2 && k < 18));
            cycle();
        end
        wait_out(16);

        // same stream with a 5-cycle output stall
        n_out = 0;
        fork
            begin
                for (int k = 0; k < 16; k++) send(rep(32'(k) * 32'h01010101), 1'b0, TAG_W'(k));
            end
            begin
                repeat (6) cycle();
                bus.out_ready = 1'b0;
                #1;
                for (int k = 0; k < 5; k++) begin
                    check($sformatf("stall_in_ready_%0d", k), DW'(bus.in_ready), DW'(1'b0));
                    cycle();
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_out(16);

        // random valid/ready, 1000 transactions
        n_out = 0;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    while ($urandom_range(0, 1) == 0) cycle();
                    for (int w = 0; w < LANES; w++) st[w*32 +: 32] = $urandom;
                    send(st, 1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, (1 << TAG_W) - 1)));
                end
            end
            begin
                guard = 0;
                while (n_out < 1000 && guard < 20000) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    cycle();
                    guard++;
                end
                bus.out_ready = 1'b1;
            end
        join
        check("rand_count", DW'(n_out), DW'(1000));
        check("sb_empty", DW'(exp_q.size()), '0);
        mon_en = 1'b0;
        cycle();

        // reset with both stages full
        bus.out_ready = 1'b0;
        send(rep(32'h11111111), 1'b0, 4'h1);
        send(rep(32'h22222222), 1'b0, 4'h2);
        check("full_in_ready", DW'(bus.in_ready), DW'(1'b0));
        check("full_out_valid", DW'(bus.out_valid), DW'(1'b1));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("mrst_out_valid", DW'(bus.out_valid), DW'(1'b0));
        check("mrst_in_ready", DW'(bus.in_ready), DW'(1'b1));
        check("mrst_out_data", bus.out_data, '0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_tag    = 4'ha;
        bus.in_state  = {32'h0, 32'h0, 32'h0, 32'h53535353};
        cycle();
        bus.in_valid = 1'b0;
        check("post_rst_n1", DW'(bus.out_valid), DW'(1'b0));
        cycle();
        check("post_rst_valid", DW'(bus.out_valid), DW'(1'b1));
        check("post_rst_lane0", DW'(bus.out_data[0 +: 128]), DW'(128'hc1eded2c_2cc1eded_ed2cc1ed_eded2cc1));
        check("post_rst_tag", DW'(bus.out_tag), DW'(4'ha));
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
